// File: rtl/systolic_pe.sv
// Weight-stationary MAC tile for a systolic array with a double-buffered weight.
// Optional macro PE_SATURATE_EN clamps the accumulation instead of wrapping.
module systolic_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ACC_W-1:0]  pe_psum_in,
    input  logic [DATA_W-1:0] pe_weight_in,
    input  logic              pe_accept_w_in,
    input  logic [DATA_W-1:0] pe_input_in,
    input  logic              pe_valid_in,
    input  logic              pe_switch_in,
    input  logic              pe_enabled,
    output logic [ACC_W-1:0]  pe_psum_out,
    output logic [DATA_W-1:0] pe_weight_out,
    output logic [DATA_W-1:0] pe_input_out,
    output logic              pe_valid_out,
    output logic              pe_switch_out
);

    localparam int PROD_W = 2 * DATA_W;

    logic [DATA_W-1:0] r_weight_active;
    logic [DATA_W-1:0] r_weight_shadow;
    logic [ACC_W-1:0]  r_psum_out;
    logic [DATA_W-1:0] r_weight_out;
    logic [DATA_W-1:0] r_input_out;
    logic              r_valid_out;
    logic              r_switch_out;

    logic signed [PROD_W-1:0] w_product;
    logic signed [ACC_W-1:0]  w_product_ext;
    logic [ACC_W-1:0]         w_mac_result;
    logic                     w_clear;

    // Signed product of the activation and the weight that was active before this edge
    always_comb begin
        w_product     = {PROD_W{1'b0}};
        w_product_ext = {ACC_W{1'b0}};
        w_product     = PROD_W'($signed(pe_input_in)) * PROD_W'($signed(r_weight_active));
        w_product_ext = ACC_W'(w_product);
    end

`ifdef PE_SATURATE_EN
    logic signed [ACC_W:0] w_sum_wide;

    // Sum at one extra bit; disagreement of the top two bits marks overflow
    always_comb begin
        w_mac_result = {ACC_W{1'b0}};
        w_sum_wide   = {w_product_ext[ACC_W-1], w_product_ext}
                     + {pe_psum_in[ACC_W-1], pe_psum_in};
        case (w_sum_wide[ACC_W:ACC_W-1])
            2'b01:   w_mac_result = {1'b0, {(ACC_W-1){1'b1}}};
            2'b10:   w_mac_result = {1'b1, {(ACC_W-1){1'b0}}};
            default: w_mac_result = w_sum_wide[ACC_W-1:0];
        endcase
    end
`else
    // Plain modulo-2^ACC_W accumulation
    always_comb begin
        w_mac_result = {ACC_W{1'b0}};
        w_mac_result = w_product_ext + pe_psum_in;
    end
`endif

    // A disabled PE behaves exactly like one held in reset
    always_comb begin
        w_clear = 1'b0;
        if (rst || !pe_enabled) begin
            w_clear = 1'b1;
        end else begin
            w_clear = 1'b0;
        end
    end

    // All state and outputs; switch reads the pre-edge shadow, so accept+switch is safe
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_weight_active <= {DATA_W{1'b0}};
            r_weight_shadow <= {DATA_W{1'b0}};
            r_psum_out      <= {ACC_W{1'b0}};
            r_weight_out    <= {DATA_W{1'b0}};
            r_input_out     <= {DATA_W{1'b0}};
            r_valid_out     <= 1'b0;
            r_switch_out    <= 1'b0;
        end else begin
            if (pe_accept_w_in) begin
                r_weight_shadow <= pe_weight_in;
                r_weight_out    <= pe_weight_in;
            end else begin
                r_weight_out    <= {DATA_W{1'b0}};
            end

            if (pe_switch_in) begin
                r_weight_active <= r_weight_shadow;
            end

            r_switch_out <= pe_switch_in;

            if (pe_valid_in) begin
                r_psum_out  <= w_mac_result;
                r_input_out <= pe_input_in;
                r_valid_out <= 1'b1;
            end else begin
                r_psum_out  <= {ACC_W{1'b0}};
                r_input_out <= {DATA_W{1'b0}};
                r_valid_out <= 1'b0;
            end
        end
    end

    assign pe_psum_out   = r_psum_out;
    assign pe_weight_out = r_weight_out;
    assign pe_input_out  = r_input_out;
    assign pe_valid_out  = r_valid_out;
    assign pe_switch_out = r_switch_out;

endmodule

// File: tb/tb_systolic_pe.sv
// Directed self-checking bench for systolic_pe with hand-computed expectations.
module tb_systolic_pe;

    logic        clk;
    logic        rst;
    logic [31:0] pe_psum_in;
    logic [7:0]  pe_weight_in;
    logic        pe_accept_w_in;
    logic [7:0]  pe_input_in;
    logic        pe_valid_in;
    logic        pe_switch_in;
    logic        pe_enabled;
    logic [31:0] pe_psum_out;
    logic [7:0]  pe_weight_out;
    logic [7:0]  pe_input_out;
    logic        pe_valid_out;
    logic        pe_switch_out;

    int n_checks = 0;
    int n_pass   = 0;

    systolic_pe #(.DATA_W(8), .ACC_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .pe_psum_in     (pe_psum_in),
        .pe_weight_in   (pe_weight_in),
        .pe_accept_w_in (pe_accept_w_in),
        .pe_input_in    (pe_input_in),
        .pe_valid_in    (pe_valid_in),
        .pe_switch_in   (pe_switch_in),
        .pe_enabled     (pe_enabled),
        .pe_psum_out    (pe_psum_out),
        .pe_weight_out  (pe_weight_out),
        .pe_input_out   (pe_input_out),
        .pe_valid_out   (pe_valid_out),
        .pe_switch_out  (pe_switch_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pe_psum_in     = 32'd0;
        pe_weight_in   = 8'd0;
        pe_accept_w_in = 1'b0;
        pe_input_in    = 8'd0;
        pe_valid_in    = 1'b0;
        pe_switch_in   = 1'b0;
    endtask

    task automatic load_weight(input logic [7:0] w);
        idle_inputs();
        pe_accept_w_in = 1'b1;
        pe_weight_in   = w;
        step();
        idle_inputs();
        pe_switch_in = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic mac(input logic [7:0] x, input logic [31:0] p);
        idle_inputs();
        pe_valid_in = 1'b1;
        pe_input_in = x;
        pe_psum_in  = p;
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst        = 1'b1;
        pe_enabled = 1'b0;
        step();
        step();
        check_val("rst_psum",   pe_psum_out, 32'd0);
        check_val("rst_weight", 32'(pe_weight_out), 32'd0);
        check_val("rst_input",  32'(pe_input_out), 32'd0);
        check_val("rst_valid",  32'(pe_valid_out), 32'd0);
        check_val("rst_switch", 32'(pe_switch_out), 32'd0);

        rst        = 1'b0;
        pe_enabled = 1'b1;
        pe_accept_w_in = 1'b1;
        pe_weight_in   = 8'd5;
        step();
        check_val("fwd_weight", 32'(pe_weight_out), 32'd5);
        idle_inputs();
        pe_switch_in = 1'b1;
        step();
        check_val("fwd_switch", 32'(pe_switch_out), 32'd1);
        check_val("fwd_weight_zero", 32'(pe_weight_out), 32'd0);
        idle_inputs();

        mac(8'd3, 32'd10);
        check_val("mac_psum",  pe_psum_out, 32'd25);
        check_val("mac_input", 32'(pe_input_out), 32'd3);
        check_val("mac_valid", 32'(pe_valid_out), 32'd1);
        check_val("switch_drop", 32'(pe_switch_out), 32'd0);

        mac(8'hFE, 32'd100);
        check_val("neg_psum",  pe_psum_out, 32'd90);
        check_val("neg_input", 32'(pe_input_out), 32'h0000_00FE);

        idle_inputs();
        pe_input_in = 8'd50;
        pe_psum_in  = 32'd50;
        step();
        check_val("inv_psum",  pe_psum_out, 32'd0);
        check_val("inv_input", 32'(pe_input_out), 32'd0);
        check_val("inv_valid", 32'(pe_valid_out), 32'd0);

        // Shadow is 5; accept 7 and switch together -> active takes old shadow 5
        idle_inputs();
        pe_accept_w_in = 1'b1;
        pe_weight_in   = 8'd7;
        pe_switch_in   = 1'b1;
        step();
        check_val("sim_fwd_weight", 32'(pe_weight_out), 32'd7);
        mac(8'd1, 32'd0);
        check_val("sim_old_shadow", pe_psum_out, 32'd5);
        pe_switch_in = 1'b1;
        step();
        mac(8'd1, 32'd0);
        check_val("sim_new_shadow", pe_psum_out, 32'd7);

        // Switch in the same cycle as a MAC: the MAC still sees the old weight
        idle_inputs();
        pe_accept_w_in = 1'b1;
        pe_weight_in   = 8'd2;
        step();
        idle_inputs();
        pe_switch_in = 1'b1;
        pe_valid_in  = 1'b1;
        pe_input_in  = 8'd1;
        step();
        check_val("mac_during_switch", pe_psum_out, 32'd7);
        mac(8'd1, 32'd0);
        check_val("mac_after_switch", pe_psum_out, 32'd2);

        load_weight(8'd127);
        mac(8'd127, 32'h7FFF_FFFF);
`ifdef PE_SATURATE_EN
        check_val("ovf_pos", pe_psum_out, 32'h7FFF_FFFF);
`else
        check_val("ovf_pos", pe_psum_out, 32'h8000_3F00);
`endif
        // 127 * -128 = -16256 added to the most negative value
        mac(8'h80, 32'h8000_0000);
`ifdef PE_SATURATE_EN
        check_val("ovf_neg", pe_psum_out, 32'h8000_0000);
`else
        check_val("ovf_neg", pe_psum_out, 32'h7FFF_C080);
`endif

        // Disabling clears outputs and both weights
        idle_inputs();
        pe_enabled  = 1'b0;
        pe_valid_in = 1'b1;
        pe_input_in = 8'd4;
        pe_psum_in  = 32'd9;
        step();
        check_val("dis_psum",  pe_psum_out, 32'd0);
        check_val("dis_valid", 32'(pe_valid_out), 32'd0);
        pe_enabled = 1'b1;
        mac(8'd1, 32'd0);
        check_val("dis_weight_cleared", pe_psum_out, 32'd0);

        // Reset mid-stream with enable high discards a loaded weight
        load_weight(8'd9);
        rst            = 1'b1;
        pe_valid_in    = 1'b1;
        pe_input_in    = 8'd2;
        pe_psum_in     = 32'd1;
        pe_switch_in   = 1'b1;
        pe_accept_w_in = 1'b1;
        pe_weight_in   = 8'd3;
        step();
        check_val("rst_mid_psum",   pe_psum_out, 32'd0);
        check_val("rst_mid_switch", 32'(pe_switch_out), 32'd0);
        check_val("rst_mid_weight", 32'(pe_weight_out), 32'd0);
        rst = 1'b0;
        mac(8'd2, 32'd1);
        check_val("rst_mid_active", pe_psum_out, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
